// File: rtl/common.sv
// Shared types for the instruction-fetch path: instruction and address types,
// the per-warp fetcher state and the fetch arbiter state.
package common;

  typedef logic [31:0] instruction_t;
  typedef logic [15:0] instruction_memory_address_t;

  typedef enum logic [1:0] {
    FETCHER_IDLE    = 2'd0,
    FETCHER_WAIT    = 2'd1,
    FETCHER_DONE    = 2'd2
  } fetcher_state_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_REQUEST = 2'd1,
    ARB_RESPOND = 2'd2
  } arbiter_state_t;

  localparam int MAX_REQUESTERS = 16;

endpackage

// File: rtl/fetch_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request bit at or after
// (last_grant + 1) mod NUM_REQUESTERS, with wrap-around.
module rr_priority_picker #(
  parameter int NUM_REQUESTERS = 4,
  parameter int IDX_W          = 2
) (
  input  logic [NUM_REQUESTERS-1:0] req,
  input  logic [IDX_W-1:0]          last_grant,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      any_grant
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_REQUESTERS; i++) begin
      cand     = (int'(last_grant) + i) % NUM_REQUESTERS;
      cand_idx = IDX_W'(cand);
      if (!any_grant && req[cand_idx]) begin
        any_grant = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter sharing one instruction-memory read port among per-warp
// fetchers. Optional counters (grant_count, stall_cycles): FETCH_ARBITER_STATS_EN.
module fetch_arbiter
  import common::*;
#(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQUESTERS-1:0]   req_read_valid,
  input  instruction_memory_address_t req_read_address [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0]   req_read_ready,
  output instruction_t                req_read_data,
  output logic                        mem_read_valid,
  output instruction_memory_address_t mem_read_address,
  input  logic                        mem_read_ready,
  input  instruction_t                mem_read_data,
  output logic                        busy,
`ifdef FETCH_ARBITER_STATS_EN
  output logic [31:0]                 grant_count,
  output logic [31:0]                 stall_cycles,
`endif
  output arbiter_state_t              state_dbg
);

  // Handshakes: a requester holds req_read_valid until it sees its one-cycle
  // req_read_ready pulse; memory sees mem_read_valid/address held stable until
  // the edge on which mem_read_ready is sampled high, and is ignored otherwise.

  localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  arbiter_state_t              state_q, state_d;
  logic [IDX_W-1:0]            grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]            last_grant_q, last_grant_d;
  logic [IDX_W-1:0]            pick_idx;
  logic                        pick_any;
  logic                        mem_valid_d;
  instruction_memory_address_t mem_addr_d;
  logic [NUM_REQUESTERS-1:0]   ready_d;
  instruction_t                data_d;

  rr_priority_picker #(
    .NUM_REQUESTERS(NUM_REQUESTERS),
    .IDX_W         (IDX_W)
  ) u_picker (
    .req       (req_read_valid),
    .last_grant(last_grant_q),
    .grant_idx (pick_idx),
    .any_grant (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    mem_valid_d  = mem_read_valid;
    mem_addr_d   = mem_read_address;
    ready_d      = '0;
    data_d       = req_read_data;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d     = ARB_REQUEST;
          grant_idx_d = pick_idx;
          mem_valid_d = 1'b1;
          mem_addr_d  = req_read_address[pick_idx];
        end
      end
      ARB_REQUEST: begin
        if (mem_read_ready) begin
          state_d              = ARB_RESPOND;
          mem_valid_d          = 1'b0;
          data_d               = mem_read_data;
          ready_d[grant_idx_q] = 1'b1;
        end
      end
      ARB_RESPOND: begin
        // Priority only advances once the response has been delivered.
        state_d      = ARB_IDLE;
        last_grant_d = grant_idx_q;
      end
      default: begin
        state_d     = ARB_IDLE;
        mem_valid_d = 1'b0;
`ifndef SYNTHESIS
        $error("fetch_arbiter: illegal state encoding %0d", state_q);
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ARB_IDLE;
      grant_idx_q      <= '0;
      last_grant_q     <= IDX_W'(NUM_REQUESTERS - 1);
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      req_read_ready   <= '0;
      req_read_data    <= '0;
    end else begin
      state_q          <= state_d;
      grant_idx_q      <= grant_idx_d;
      last_grant_q     <= last_grant_d;
      mem_read_valid   <= mem_valid_d;
      mem_read_address <= mem_addr_d;
      req_read_ready   <= ready_d;
      req_read_data    <= data_d;
    end
  end

  assign busy      = (state_q != ARB_IDLE);
  assign state_dbg = state_q;

`ifdef FETCH_ARBITER_STATS_EN
  logic [NUM_REQUESTERS-1:0] served_mask;
  logic                      stall;

  // The requester being picked (IDLE) or served (otherwise) is not stalled.
  always_comb begin
    served_mask = '0;
    if (state_q == ARB_IDLE) begin
      if (pick_any) served_mask[pick_idx] = 1'b1;
    end else begin
      served_mask[grant_idx_q] = 1'b1;
    end
  end

  assign stall = |(req_read_valid & ~served_mask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_count  <= '0;
      stall_cycles <= '0;
    end else begin
      if (state_q == ARB_IDLE && pick_any && grant_count != '1)
        grant_count <= grant_count + 32'd1;
      if (stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_arbiter.sv
// Bench for fetch_arbiter: reset checks, vector table of grant patterns,
// hand-written multi-cycle sequences, scoreboard on req_read_ready pulses.
module tb_fetch_arbiter;
  import common::*;

  localparam int N    = 4;
  localparam int SB_W = 36;

  logic                        clk = 1'b0;
  logic                        reset_n = 1'b1;
  logic [N-1:0]                req_read_valid;
  instruction_memory_address_t req_read_address [N];
  logic [N-1:0]                req_read_ready;
  instruction_t                req_read_data;
  logic                        mem_read_valid;
  instruction_memory_address_t mem_read_address;
  logic                        mem_read_ready;
  instruction_t                mem_read_data;
  logic                        busy;
  arbiter_state_t              state_dbg;
`ifdef FETCH_ARBITER_STATS_EN
  logic [31:0]                 grant_count;
  logic [31:0]                 stall_cycles;
`endif

  fetch_arbiter #(.NUM_REQUESTERS(N)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_read_valid  (req_read_valid),
    .req_read_address(req_read_address),
    .req_read_ready  (req_read_ready),
    .req_read_data   (req_read_data),
    .mem_read_valid  (mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready  (mem_read_ready),
    .mem_read_data   (mem_read_data),
    .busy            (busy),
`ifdef FETCH_ARBITER_STATS_EN
    .grant_count     (grant_count),
    .stall_cycles    (stall_cycles),
`endif
    .state_dbg       (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [SB_W-1:0] exp_q[$];

  int   stall_exp   = 0;
  logic count_stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic set_addrs(input int base, input int stride);
    for (int i = 0; i < N; i++) req_read_address[i] = 16'(base + i * stride);
  endtask

  // ---------------- driver ----------------
  // Waits for the grant, checks the address, holds memory off for lat cycles,
  // then completes and pushes the expected {index, data} response.
  task automatic serve(input int exp_idx, input instruction_memory_address_t exp_addr,
                       input int lat, input instruction_t data,
                       input logic [N-1:0] set_mask, input logic [N-1:0] clr_mask);
    int n;
    n = 0;
    while (mem_read_valid !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    check("grant_seen", 64'(mem_read_valid), 64'd1);
    if (mem_read_valid === 1'b1) begin
      check("mem_addr", 64'(mem_read_address), 64'(exp_addr));
      check("busy_request", 64'(busy), 64'd1);
      req_read_valid = (req_read_valid | set_mask) & ~clr_mask;
      for (int i = 0; i < lat; i++) begin
        tick(1);
        check("mem_hold_valid", 64'(mem_read_valid), 64'd1);
        check("mem_hold_addr", 64'(mem_read_address), 64'(exp_addr));
        check("no_early_ready", 64'(req_read_ready), 64'd0);
      end
      mem_read_ready = 1'b1;
      mem_read_data  = data;
      exp_q.push_back({4'(exp_idx), data});
      tick(1);
      mem_read_ready = 1'b0;
      mem_read_data  = $urandom;
      check("respond_state", 64'(state_dbg), 64'(ARB_RESPOND));
      check("mem_valid_clear", 64'(mem_read_valid), 64'd0);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n && req_read_ready !== '0) begin
      if ($countones(req_read_ready) != 1) begin
        check("ready_onehot", 64'($countones(req_read_ready)), 64'd1);
      end else if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'(req_read_ready), 64'd0);
      end else begin
        logic [SB_W-1:0] e;
        logic [3:0]      idx;
        idx = '0;
        for (int i = 0; i < N; i++) if (req_read_ready[i]) idx = 4'(i);
        e = exp_q.pop_front();
        check("sb_response", 64'({idx, req_read_data}), 64'(e));
      end
    end
    if (count_stall && $countones(req_read_valid) >= 2) stall_exp++;
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [N-1:0] mask;
    int           exp_idx;
    int           lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, got timeout, required finish");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int prev;
    int rem[2];
    instruction_t d;

    // last_grant is 2 when the table starts (after the requester-2 fetch)
    vecs[0] = '{4'b1111, 3, 0};
    vecs[1] = '{4'b0110, 1, 1};
    vecs[2] = '{4'b0010, 1, 2};
    vecs[3] = '{4'b1001, 3, 3};
    vecs[4] = '{4'b1000, 3, 0};
    vecs[5] = '{4'b0101, 0, 1};
    vecs[6] = '{4'b0101, 2, 2};
    vecs[7] = '{4'b0001, 0, 3};

    req_read_valid = '0;
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
    set_addrs(0, 8);

    // Reset state, then 10 idle cycles with no requests.
    #1 reset_n = 1'b0;
    #2;
    check("rst_state", 64'(state_dbg), 64'(ARB_IDLE));
    check("rst_mem_valid", 64'(mem_read_valid), 64'd0);
    check("rst_ready", 64'(req_read_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_addr", 64'(mem_read_address), 64'd0);
    check("rst_data", 64'(req_read_data), 64'd0);
    tick(2);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("idle_mem_valid", 64'(mem_read_valid), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end

    // Single requester 2 at 0x10, zero-wait memory: 3-cycle service.
    req_read_valid = 4'b0100;
    start = cyc;
    serve(2, 16'h0010, 0, 32'hDEADBEEF, '0, '0);
    check("single_ready", 64'(req_read_ready), 64'h4);
    check("single_data", 64'(req_read_data), 64'hDEADBEEF);
    req_read_valid = '0;
    tick(1);
    check("single_ready_off", 64'(req_read_ready), 64'd0);
    check("single_idle", 64'(state_dbg), 64'(ARB_IDLE));
    check("single_busy_off", 64'(busy), 64'd0);
    check("single_cycles", 64'(cyc - start), 64'd3);
    tick(2);
    check("data_hold", 64'(req_read_data), 64'hDEADBEEF);

    // Table of request patterns with varying memory latency.
    set_addrs(16'h100, 4);
    for (int v = 0; v < 8; v++) begin
      req_read_valid = vecs[v].mask;
      d = $urandom;
      serve(vecs[v].exp_idx, 16'(16'h100 + vecs[v].exp_idx * 4), vecs[v].lat, d, '0, '0);
      req_read_valid = '0;
      tick(1);
      check("vec_idle", 64'(state_dbg), 64'(ARB_IDLE));
    end

    // All four continuously valid: order 0,1,2,3,0 at one grant per 3 cycles.
    do_reset();
    set_addrs(0, 4);
    req_read_valid = 4'hF;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      serve(k % 4, 16'((k % 4) * 4), 0, $urandom, '0, '0);
      if (k > 0) check("rr_spacing", 64'(cyc - prev), 64'd3);
      prev = cyc;
    end
    req_read_valid = '0;
    tick(2);

    // Long memory wait; requester 0 drops after grant, requester 1 arrives.
    set_addrs(16'h200, 4);
    req_read_valid = 4'b0001;
    serve(0, 16'h200, 5, $urandom, 4'b0010, 4'b0001);
    check("late_ready0", 64'(req_read_ready), 64'h1);
    tick(1);
    check("no_grant_on_exit", 64'(mem_read_valid), 64'd0);
    check("exit_idle", 64'(state_dbg), 64'(ARB_IDLE));
    serve(1, 16'h204, 0, $urandom, '0, '0);
    req_read_valid = '0;
    tick(2);

    // Reset during ARB_REQUEST, then a stray memory completion.
    set_addrs(16'h300, 4);
    req_read_valid = 4'b1000;
    begin
      int n;
      n = 0;
      while (mem_read_valid !== 1'b1 && n < 50) begin
        tick(1);
        n++;
      end
    end
    check("abort_grant", 64'(mem_read_valid), 64'd1);
    check("abort_addr", 64'(mem_read_address), 64'h30C);
    reset_n = 1'b0;
    #2;
    check("abort_state", 64'(state_dbg), 64'(ARB_IDLE));
    check("abort_mem_valid", 64'(mem_read_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_mem_addr", 64'(mem_read_address), 64'd0);
    check("abort_data", 64'(req_read_data), 64'd0);
    reset_n = 1'b1;
    req_read_valid = '0;
    tick(1);
    mem_read_ready = 1'b1;
    mem_read_data  = $urandom;
    tick(2);
    mem_read_ready = 1'b0;
    check("stray_idle", 64'(state_dbg), 64'(ARB_IDLE));
    check("stray_no_ready", 64'(req_read_ready), 64'd0);
    req_read_valid = 4'b1001;
    serve(0, 16'h300, 1, $urandom, '0, '0);
    req_read_valid = '0;
    tick(2);

`ifdef FETCH_ARBITER_STATS_EN
    // Two requesters, two fetches each: grants 0,1,0,1.
    do_reset();
    check("stats_grant_rst", 64'(grant_count), 64'd0);
    check("stats_stall_rst", 64'(stall_cycles), 64'd0);
    set_addrs(16'h400, 4);
    rem[0] = 2;
    rem[1] = 2;
    stall_exp = 0;
    count_stall = 1'b1;
    req_read_valid = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      serve(k % 2, 16'(16'h400 + (k % 2) * 4), 0, $urandom, '0, '0);
      rem[k % 2]--;
      if (rem[k % 2] == 0) req_read_valid[k % 2] = 1'b0;
    end
    tick(2);
    count_stall = 1'b0;
    check("stats_grant_count", 64'(grant_count), 64'd4);
    check("stats_stall_cycles", 64'(stall_cycles), 64'(stall_exp));
`endif

    tick(3);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
